// File: rtl/gray_to_bin_rx.sv
// gray_to_bin_rx
// Receives a stream of Gray-coded words and decodes each one to binary.
// Each decoded word is held in a single output register. Every transition is
// classified against the previously accepted word: HOLD, UP, DOWN or JUMP.
// Illegal jumps are counted in a saturating counter.
//
// Handshake (both sides): a word moves when valid && ready are high at a rising
// clk edge. in_ready = !out_valid || out_ready, so the single output register
// can be refilled in the same cycle it drains (one word per clock). While
// out_valid && !out_ready, every output holds stable and no input is taken.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_gray  [WIDTH]      Gray-coded input word
//   out_valid/out_ready   output handshake
//   out_bin  [WIDTH]      decoded binary word
//   out_dir  [2]          00 HOLD, 01 UP, 10 DOWN, 11 JUMP
//   out_first             first word since reset or clear
//   out_err              illegal transition (JUMP)
//   err_count[ERR_CNT_W] saturating count of accepted JUMP words
//   clear                 synchronous: forget reference word, zero err_count
module gray_to_bin_rx #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic [1:0]           out_dir,
  output logic                 out_first,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clear
);

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_JUMP = 2'b11;

  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  typedef enum logic {
    NO_REF   = 1'b0,
    HAVE_REF = 1'b1
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] ref_gray;
  logic [WIDTH-1:0] ref_bin;
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  logic             first_nx;
  logic [1:0]       dir_nx;
  logic             err_nx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign bin_dec[i] = ^in_gray[WIDTH-1:i];
  end

  // Exactly one bit differs from the reference Gray word.
  assign diff    = in_gray ^ ref_gray;
  assign one_bit = (diff != '0) && ((diff & (diff - ONE)) == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NO_REF;
    else        state <= state_nx;
  end

  // Next state. A word accepted together with clear becomes the new reference,
  // so the machine lands in HAVE_REF. A clear on its own drops the reference.
  always_comb begin
    state_nx = state;
    if (clear)       state_nx = accept ? HAVE_REF : NO_REF;
    else if (accept) state_nx = HAVE_REF;
  end

  // Output decode: classification of the word on in_gray against the reference.
  always_comb begin
    first_nx = (state == NO_REF) || clear;
    dir_nx   = DIR_HOLD;
    err_nx   = 1'b0;
    if (!first_nx) begin
      if (diff == '0) begin
        dir_nx = DIR_HOLD;
      end else if (one_bit && (bin_dec == ref_bin + ONE)) begin
        dir_nx = DIR_UP;
      end else if (one_bit && (bin_dec == ref_bin - ONE)) begin
        dir_nx = DIR_DOWN;
      end else begin
        dir_nx = DIR_JUMP;
        err_nx = 1'b1;
      end
    end
  end

  // Reference word and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_gray  <= '0;
      ref_bin   <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_dir   <= DIR_HOLD;
      out_first <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      ref_gray  <= in_gray;
      ref_bin   <= bin_dec;
      out_valid <= 1'b1;
      out_bin   <= bin_dec;
      out_dir   <= dir_nx;
      out_first <= first_nx;
      out_err   <= err_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error counter counts at acceptance, not at output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (accept && err_nx && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_to_bin_rx.sv
// Testbench for gray_to_bin_rx (WIDTH=4, ERR_CNT_W=2 so saturation is reachable).
// Table-driven vectors go through a driver task that pushes each expected output
// record to exp_q. A negedge monitor pops and compares on every output handshake.
// Hand-written sequences cover backpressure, clear and asynchronous reset.
module tb_gray_to_bin_rx;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int EW = W + 2 + 1 + 1 + CW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_gray;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bin;
  logic [1:0]    out_dir;
  logic          out_first;
  logic          out_err;
  logic [CW-1:0] err_count;
  logic          clear;

  typedef struct {
    logic          clr;
    logic [W-1:0]  gray;
    logic [W-1:0]  bin;
    logic [1:0]    dir;
    logic          first;
    logic          err;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  gray_to_bin_rx #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_dir   (out_dir),
    .out_first (out_first),
    .out_err   (out_err),
    .err_count (err_count),
    .clear     (clear)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic clr, input logic [W-1:0] gray, input logic [W-1:0] bin,
                              input logic [1:0] dir, input logic first, input logic err,
                              input logic [CW-1:0] cnt);
    vec_t v;
    v.clr = clr; v.gray = gray; v.bin = bin; v.dir = dir;
    v.first = first; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [EW-1:0] pack_exp(input vec_t v);
    return {v.bin, v.dir, v.first, v.err, v.cnt};
  endfunction

  // Compare the current DUT output word against one expected record.
  task automatic cmp_word(input logic [EW-1:0] e);
    logic [EW-1:0] act;
    act = {out_bin, out_dir, out_first, out_err, err_count};
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL word: got bin=%b dir=%b first=%b err=%b cnt=%0d expected bin=%b dir=%b first=%b err=%b cnt=%0d @%0t",
               out_bin, out_dir, out_first, out_err, err_count,
               e[EW-1 -: W], e[CW+3:CW+2], e[CW+1], e[CW], e[CW-1:0], $time);
    end
  endtask

  // Monitor: a handshake completes at the next posedge when both are high now.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got bin=%b with empty queue @%0t", out_bin, $time);
      end else begin
        cmp_word(exp_q.pop_front());
      end
    end
  end

  // Driver: present one word, wait (bounded) for in_ready, accept on next posedge.
  task automatic send(input vec_t v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_gray  = v.gray;
    clear    = v.clr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck 0 for gray=%b, expected 1", v.gray);
    end else begin
      exp_q.push_back(pack_exp(v));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    logic [W-1:0] gc [16];
    vec_t v;
    gc = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Vector tables
    for (int i = 0; i < 16; i++)
      tbl_a.push_back(mk(1'b0, gc[i], 4'(i), (i == 0) ? 2'b00 : 2'b01, (i == 0), 1'b0, 2'd0));
    tbl_a.push_back(mk(0, 4'b0000, 4'd0,  2'b01, 0, 0, 2'd0)); // wrap 15 -> 0 UP
    tbl_a.push_back(mk(0, 4'b1000, 4'd15, 2'b10, 0, 0, 2'd0)); // 0 -> 15 DOWN
    tbl_a.push_back(mk(0, 4'b1001, 4'd14, 2'b10, 0, 0, 2'd0)); // 15 -> 14 DOWN
    tbl_a.push_back(mk(0, 4'b1000, 4'd15, 2'b01, 0, 0, 2'd0));
    tbl_a.push_back(mk(0, 4'b0000, 4'd0,  2'b01, 0, 0, 2'd0));
    tbl_a.push_back(mk(0, 4'b0011, 4'd2,  2'b11, 0, 1, 2'd1)); // illegal jump
    tbl_a.push_back(mk(0, 4'b0010, 4'd3,  2'b01, 0, 0, 2'd1)); // UP from the jump word
    tbl_a.push_back(mk(0, 4'b0110, 4'd4,  2'b01, 0, 0, 2'd1));
    tbl_a.push_back(mk(0, 4'b0111, 4'd5,  2'b01, 0, 0, 2'd1));
    tbl_a.push_back(mk(0, 4'b0101, 4'd6,  2'b01, 0, 0, 2'd1));
    tbl_a.push_back(mk(0, 4'b0100, 4'd7,  2'b01, 0, 0, 2'd1));
    tbl_a.push_back(mk(0, 4'b1100, 4'd8,  2'b01, 0, 0, 2'd1));
    // after 1101 (bin 9): five jumps, counter saturates at 3, then clear + accept
    tbl_b.push_back(mk(0, 4'b0000, 4'd0, 2'b11, 0, 1, 2'd2));
    tbl_b.push_back(mk(0, 4'b1101, 4'd9, 2'b11, 0, 1, 2'd3));
    tbl_b.push_back(mk(0, 4'b0000, 4'd0, 2'b11, 0, 1, 2'd3));
    tbl_b.push_back(mk(0, 4'b1101, 4'd9, 2'b11, 0, 1, 2'd3));
    tbl_b.push_back(mk(0, 4'b0000, 4'd0, 2'b11, 0, 1, 2'd3));
    tbl_b.push_back(mk(1, 4'b0110, 4'd4, 2'b00, 1, 0, 2'd0));

    // Reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gray   = '0;
    out_ready = 1'b1;
    clear     = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_bin",   32'(out_bin),   0);
    chk("rst_out_dir",   32'(out_dir),   0);
    chk("rst_out_first", 32'(out_first), 0);
    chk("rst_out_err",   32'(out_err),   0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Count, wrap, reverse, illegal jump
    foreach (tbl_a[i]) send(tbl_a[i]);

    // Backpressure: word 1000 held, 1101 waiting at the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_bin",   32'(out_bin),   32'b1000);
      chk("bp_in_ready",  32'(in_ready),  0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(pack_exp(mk(0, 4'b1101, 4'd9, 2'b01, 0, 0, 2'd1)));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Saturation, then clear together with an accept
    foreach (tbl_b[i]) send(tbl_b[i]);

    // Clear alone does not drop the word in the output register
    out_ready = 1'b0;
    clear     = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_keep_valid", 32'(out_valid), 1);
    chk("clr_keep_bin",   32'(out_bin),   4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(0, 4'b0000, 4'd0, 2'b00, 1, 0, 2'd0)); // first word after clear
    send(mk(0, 4'b0011, 4'd2, 2'b11, 0, 1, 2'd1));

    // Async reset between edges while a word is held
    out_ready = 1'b0;
    @(negedge clk);
    cmp_word(exp_q.pop_front());
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_bin",   32'(out_bin),   0);
    chk("arst_err_count", 32'(err_count), 0);
    chk("arst_queue",     32'(exp_q.size()), 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(mk(0, 4'b0010, 4'd3, 2'b00, 1, 0, 2'd0));
    send(mk(0, 4'b0110, 4'd4, 2'b01, 0, 0, 2'd0));

    // Drain
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
